// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module muldiv_unit #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] xs1,
    input  logic [width-1:0] xs2,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);

    localparam int unsigned CntW = $clog2(width);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [width-1:0]   opnd_q;
    logic [2*width-1:0] acc_q;
    logic [CntW-1:0]    cnt_q;
    logic [width-1:0]   result_q;

    logic               accept, last_step;
    logic               sgn1, sgn2, neg_in, div_zero, div_ovf, special;
    logic [width-1:0]   abs1, abs2, special_res;

    assign accept    = (state_q == StIdle) && start;
    assign last_step = (cnt_q == CntW'(width - 1));

    // Operand decode at accept: magnitudes, result sign and the divide special cases.
    always_comb begin
        sgn1     = xs1[width-1] & (funct3 inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem});
        sgn2     = xs2[width-1] & (funct3 inside {OpMul, OpMulh, OpDiv, OpRem});
        abs1     = sgn1 ? -xs1 : xs1;
        abs2     = sgn2 ? -xs2 : xs2;
        neg_in   = (funct3 == OpRem) ? sgn1 : (sgn1 ^ sgn2);
        div_zero = funct3[2] && (xs2 == '0);
        div_ovf  = (funct3 == OpDiv || funct3 == OpRem) &&
                   (xs1 == {1'b1, {(width-1){1'b0}}}) && (xs2 == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = funct3[1] ? xs1 : '1;
        end else begin
            special_res = funct3[1] ? '0 : xs1;
        end
    end

    // One iteration: multiplier bits leave acc from the bottom, quotient bits enter it.
    logic [width:0]     mul_sum, rem_sh, div_diff;
    logic [2*width-1:0] step_acc;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*width-1:width]} + ({1'b0, opnd_q} & {(width+1){acc_q[0]}});
        rem_sh   = {acc_q[2*width-1:width], acc_q[width-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        if (!op_q[2]) begin
            step_acc = {mul_sum, acc_q[width-1:1]};
        end else if (div_diff[width]) begin
            step_acc = {rem_sh[width-1:0], acc_q[width-2:0], 1'b0};
        end else begin
            step_acc = {div_diff[width-1:0], acc_q[width-2:0], 1'b1};
        end
    end

    logic [2*width-1:0] prod;
    logic [width-1:0]   quo, rmd, run_res;

    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[width-1:0] : step_acc[width-1:0];
        rmd  = neg_q ? -step_acc[2*width-1:width] : step_acc[2*width-1:width];
        case (op_q)
            OpMul:                    run_res = prod[width-1:0];
            OpMulh, OpMulhsu, OpMulhu: run_res = prod[2*width-1:width];
            OpDiv, OpDivu:            run_res = quo;
            OpRem, OpRemu:            run_res = rmd;
            default:                  run_res = '0;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*width-1:0] fast_a, fast_b, fast_prod;
    logic [width-1:0]   fast_res;

    // Sign-extending to 2*width makes the truncated unsigned product correct for every variant.
    always_comb begin
        fast_a    = {{width{xs1[width-1] & (funct3 != OpMulhu)}}, xs1};
        fast_b    = {{width{xs2[width-1] & (funct3 inside {OpMul, OpMulh})}}, xs2};
        fast_prod = fast_a * fast_b;
        fast_res  = (funct3 == OpMul) ? fast_prod[width-1:0] : fast_prod[2*width-1:width];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (special) begin
                        state_d = StDone;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!funct3[2]) begin
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        result = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= funct3;
            neg_q  <= neg_in;
            cnt_q  <= '0;
            opnd_q <= funct3[2] ? abs2 : abs1;
            acc_q  <= {{width{1'b0}}, funct3[2] ? abs1 : abs2};
            if (special) begin
                result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!funct3[2]) begin
                result_q <= fast_res;
`endif
            end
        end else if (state_q == StRun) begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + CntW'(1);
            if (last_step) begin
                result_q <= run_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus random ops against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] xs1;
    logic [W-1:0] xs2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.width(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .xs1    (xs1),
        .xs2    (xs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic with the RV32M corner-case rules.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = longint'(unsigned'(ua)) * longint'(unsigned'(ub)); return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Edges from the accepting edge (counted as 1) to the edge that raises done.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; inputs are scrambled after acceptance. poke>0 raises start at that RUN cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input string tag);
        int   edges;
        logic busy_ok;
        logic [31:0] exp;
        exp = ref_res(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; xs1 = a; xs2 = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); xs1 = $urandom; xs2 = $urandom;
        edges   = 1;
        busy_ok = 1'b1;
        while (edges < 100 && done !== 1'b1) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start  = (edges == poke);
            funct3 = 3'($urandom); xs1 = $urandom; xs2 = $urandom;
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat(f, a, b)));
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_run"}, 32'(busy_ok & busy), 32'd1);
        @(posedge clk); #1;
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_held"}, result, exp);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; start = 1'b0; funct3 = 3'd0; xs1 = '0; xs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh_m1");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu");
        run_op(3'd0, 32'd6, 32'd7, 0, "mul_6x7");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_-7/2");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu_100/7");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu_100/7");
        run_op(3'd5, 32'd42, 32'd6, 0, "divu_42/6");
        run_op(3'd4, 32'd5, 32'd0, 0, "div_by0");
        run_op(3'd6, 32'd5, 32'd0, 0, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 5, "start_in_run");

        // Reset during RUN: no done, busy and result cleared next cycle.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; xs1 = 32'd1000; xs2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done | seen), 32'd0);
        check("midrun_rst_result", result, 32'd0);

        // Start and reset together: reset wins.
        @(negedge clk);
        start = 1'b1; reset = 1'b1; funct3 = 3'd4; xs1 = 32'd9; xs2 = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        check("start_rst_busy", 32'(busy), 32'd0);
        check("start_rst_result", result, 32'd0);

        // Start held through DONE: next op accepted in the IDLE cycle after done.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; xs1 = 32'd5; xs2 = 32'd0;
        @(posedge clk); #1;
        check("held_first_done", 32'(done), 32'd1);
        check("held_first_result", result, 32'hFFFF_FFFF);
        funct3 = 3'd6; xs1 = 32'd9;
        @(posedge clk); #1;
        check("held_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check("held_second_done", 32'(done), 32'd1);
        check("held_second_result", result, 32'd9);
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
